execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the TinyRISC 5-stage pipeline, directly downstream of the operand-fetch stage's OF/EX register.
- Consumes instruction, control word, A, B, op2, PC and branch target.
- Performs ALU and branch resolution; multiply is single-cycle; div/mod use an iterative 32-step signed divider that stalls the front end.
- Drives the EX/MA pipeline register and the taken-branch redirect.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSTR, 32'h6800_0000, bubble instruction inserted on stall/reset (nop opcode 6'b011010).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- instruction_EX  in  32  instruction in EX.
- ControlWord  in  22  {isRet,isWb,isImmediate,isUBranch,isBeq,isBgt,isCall,isCmp,isAdd,isSub,isLd,isSt,isOr,isNot,isAnd,isDiv,isMod,isMov,isMul,isLsl,isLsr,isAsr}; bit21=isRet … bit0=isAsr.
- BranchTarget  in  32  resolved target (absolute for call, PC-relative otherwise).
- A  in  32  operand 1 (ra for ret).
- B  in  32  operand 2 or extended immediate.
- op2  in  32  store data.
- PC  in  32  PC of instruction in EX.
- stall  out  1  freeze IF/OF; hold OF/EX contents.
- isBranchTaken  out  1  combinational redirect request.
- branchPC  out  32  redirect target.
- instruction_MA  out  32  EX/MA register.
- ControlWord_MA  out  22  EX/MA register.
- aluResult_MA  out  32  EX/MA register.
- op2_MA  out  32  EX/MA register.
- PC_MA  out  32  EX/MA register.

Behaviour:
- Reset (rst_n=0 at posedge): instruction_MA=NOP_INSTR; ControlWord_MA, aluResult_MA, op2_MA, PC_MA = 0; flags E=GT=0; divider FSM=IDLE. stall=0 and isBranchTaken=0 while rst_n=0.
- Single-cycle ops:
  - add/ld/st: A+B; sub: A-B (mod 2^32).
  - mul: low 32 bits of A*B.
  - and/or: bitwise; not: ~B; mov: B.
  - lsl/lsr/asr: A shifted by B[4:0].
  - cmp: result 0.
  - branches/call: call result PC+4; others 0.
- Flags: on cmp with stall=0, at the edge E<=(A==B) and GT<=($signed(A)>$signed(B)). Other instructions leave flags unchanged.
- Branch resolution, combinational from the flags registers:
  - isBranchTaken = ~stall & (isUBranch | (isBeq&E) | (isBgt&GT)).
  - branchPC = isRet ? A : BranchTarget.
  - A cmp in EX at cycle t is seen by a beq in EX at t+1.
- EX/MA update, every posedge, when stall=0: latch instruction, ControlWord, result, op2, PC. When stall=1: latch bubble (NOP_INSTR, ControlWord 0, data 0).
- Divider FSM: IDLE, BUSY, DONE.
  - IDLE with isDiv|isMod:
    - stall=1 combinationally.
    - If B==0: go DONE with q=32'hFFFF_FFFF, r=A.
    - Else: latch |A|, |B| and signs; count=31; go BUSY.
  - BUSY: one restoring shift-subtract step per cycle; stall=1; count==0 -> DONE.
  - DONE: stall=0; result = signed quotient (div) or remainder (mod); EX/MA captures; go IDLE.
  - Signs: quotient truncates toward zero; remainder takes the dividend's sign.
  - Timing: normal div occupies EX 34 cycles, stall high 33. Divide-by-zero occupies 2 cycles, stall high 1.
  - Back-to-back div: the second enters IDLE in the cycle after DONE.
- Upstream holds OF/EX inputs stable while stall=1. Divider operand registers are used only in BUSY/DONE.
- rst_n low mid-division aborts to IDLE, drops stall, and inserts a bubble.

Decomposition:
- Package tinyrisc_pkg holds:
  - Control-word bit index constants (CW_ISRET=21 … CW_ISASR=0).
  - NOP_INSTR.
  - Divider state enum.
- Sub-module iter_divider (start, a, b, busy, done, quotient, remainder) with its own FSM.
- ALU, flags and EX/MA register stay in execute_stage.

Test Plan:
- add with A=5, B=7 -> next edge aluResult_MA=12, ControlWord_MA=input word, stall=0.
- cmp A=3, B=3 then beq with BranchTarget=0x40 -> during beq cycle isBranchTaken=1, branchPC=0x40. Repeat with A=3, B=4 -> isBranchTaken=0.
- div A=100, B=7 -> stall high exactly 33 cycles, EX/MA bubbles meanwhile, then aluResult_MA=14. mod A=-7, B=2 -> 32'hFFFF_FFFF (-1). div A=-7, B=2 -> -3.
- div A=9, B=0 -> stall 1 cycle, aluResult_MA=32'hFFFF_FFFF. mod A=9, B=0 -> 9.
- asr A=32'h8000_0000, B=4 -> 32'hF800_0000. lsr with the same operands -> 32'h0800_0000. lsl A=1, B=33 -> 2.
- ret with A=0x1234 -> isBranchTaken=1, branchPC=0x1234.
- rst_n low on BUSY cycle 10 of a div -> stall=0 next cycle, instruction_MA=NOP_INSTR, FSM IDLE.

Source files
------------

// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC definitions: control-word bit positions, bubble encoding, divider states.
// No logic; imported by the EX stage and its iterative divider.
package tinyrisc_pkg;

   localparam int CW_W         = 22;
   localparam int CW_ISRET     = 21;
   localparam int CW_ISWB      = 20;
   localparam int CW_ISIMM     = 19;
   localparam int CW_ISUBRANCH = 18;
   localparam int CW_ISBEQ     = 17;
   localparam int CW_ISBGT     = 16;
   localparam int CW_ISCALL    = 15;
   localparam int CW_ISCMP     = 14;
   localparam int CW_ISADD     = 13;
   localparam int CW_ISSUB     = 12;
   localparam int CW_ISLD      = 11;
   localparam int CW_ISST      = 10;
   localparam int CW_ISOR      = 9;
   localparam int CW_ISNOT     = 8;
   localparam int CW_ISAND     = 7;
   localparam int CW_ISDIV     = 6;
   localparam int CW_ISMOD     = 5;
   localparam int CW_ISMOV     = 4;
   localparam int CW_ISMUL     = 3;
   localparam int CW_ISLSL     = 2;
   localparam int CW_ISLSR     = 1;
   localparam int CW_ISASR     = 0;

   // nop opcode 6'b011010 in the top six bits
   localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

endpackage

// File: rtl/execute_stage_divider.sv
// Iterative signed divider: one restoring step per cycle, XLEN steps, then one DONE cycle.
// Divide-by-zero skips straight to DONE (q = all ones, r = dividend); start is ignored unless IDLE.
module iter_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   import tinyrisc_pkg::*;

   localparam int CNT_W = $clog2(XLEN);

   div_state_t       state;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  q_reg, r_reg, d_reg;
   logic             neg_q, neg_r;
   logic [XLEN-1:0]  abs_a, abs_b, r_shift;
   logic [XLEN:0]    r_diff;

   always_comb begin
      abs_a   = a[XLEN-1] ? -a : a;
      abs_b   = b[XLEN-1] ? -b : b;
      r_shift = {r_reg[XLEN-2:0], q_reg[XLEN-1]};
      // borrow out of the extra bit means the trial subtraction must be undone
      r_diff  = {r_reg, q_reg[XLEN-1]} - {1'b0, d_reg};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= DIV_IDLE;
         count <= '0;
         q_reg <= '0;
         r_reg <= '0;
         d_reg <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     q_reg <= '1;
                     r_reg <= a;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= DIV_DONE;
                  end else begin
                     q_reg <= abs_a;
                     r_reg <= '0;
                     d_reg <= abs_b;
                     neg_q <= a[XLEN-1] ^ b[XLEN-1];
                     neg_r <= a[XLEN-1];
                     count <= CNT_W'(XLEN - 1);
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (!r_diff[XLEN]) begin
                  r_reg <= r_diff[XLEN-1:0];
                  q_reg <= {q_reg[XLEN-2:0], 1'b1};
               end else begin
                  r_reg <= r_shift;
                  q_reg <= {q_reg[XLEN-2:0], 1'b0};
               end
               if (count == '0) state <= DIV_DONE;
               else             count <= count - 1'b1;
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

   assign busy      = (state == DIV_BUSY);
   assign done      = (state == DIV_DONE);
   assign quotient  = neg_q ? -q_reg : q_reg;
   assign remainder = neg_r ? -r_reg : r_reg;

endmodule

// File: rtl/execute_stage.sv
// TinyRISC EX stage: single-cycle ALU/branch resolution into the EX/MA register; div/mod take 34 cycles.
// stall freezes IF/OF while a divide is in flight; EX/MA receives bubbles until the divide completes.
module execute_stage #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = tinyrisc_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instruction_EX,
   input  logic [21:0]     ControlWord,
   input  logic [XLEN-1:0] BranchTarget,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [XLEN-1:0] op2,
   input  logic [XLEN-1:0] PC,
   output logic            stall,
   output logic            isBranchTaken,
   output logic [XLEN-1:0] branchPC,
   output logic [31:0]     instruction_MA,
   output logic [21:0]     ControlWord_MA,
   output logic [XLEN-1:0] aluResult_MA,
   output logic [XLEN-1:0] op2_MA,
   output logic [XLEN-1:0] PC_MA
);
   import tinyrisc_pkg::*;

   logic            is_div_op, div_busy, div_done;
   logic [XLEN-1:0] quotient, remainder, alu_result;
   logic            flag_e, flag_gt;

   assign is_div_op = ControlWord[CW_ISDIV] | ControlWord[CW_ISMOD];

   iter_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (is_div_op),
      .a         (A),
      .b         (B),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // divider IDLE with a div/mod in EX, or BUSY; DONE releases the front end
   assign stall = rst_n & (div_busy | (is_div_op & ~div_done));

   assign isBranchTaken = rst_n & ~stall & (ControlWord[CW_ISUBRANCH]
                        | (ControlWord[CW_ISBEQ] & flag_e)
                        | (ControlWord[CW_ISBGT] & flag_gt));
   assign branchPC = ControlWord[CW_ISRET] ? A : BranchTarget;

   always_comb begin
      alu_result = '0;
      if (ControlWord[CW_ISADD] | ControlWord[CW_ISLD] | ControlWord[CW_ISST]) alu_result = A + B;
      else if (ControlWord[CW_ISSUB]) alu_result = A - B;
      else if (ControlWord[CW_ISMUL]) alu_result = A * B;
      else if (ControlWord[CW_ISAND]) alu_result = A & B;
      else if (ControlWord[CW_ISOR])  alu_result = A | B;
      else if (ControlWord[CW_ISNOT]) alu_result = ~B;
      else if (ControlWord[CW_ISMOV]) alu_result = B;
      else if (ControlWord[CW_ISLSL]) alu_result = A << B[4:0];
      else if (ControlWord[CW_ISLSR]) alu_result = A >> B[4:0];
      else if (ControlWord[CW_ISASR]) alu_result = $signed(A) >>> B[4:0];
      else if (ControlWord[CW_ISDIV]) alu_result = quotient;
      else if (ControlWord[CW_ISMOD]) alu_result = remainder;
      else if (ControlWord[CW_ISCALL]) alu_result = PC + XLEN'(4);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_e  <= 1'b0;
         flag_gt <= 1'b0;
      end else if (ControlWord[CW_ISCMP] && !stall) begin
         flag_e  <= (A == B);
         flag_gt <= ($signed(A) > $signed(B));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || stall) begin
         instruction_MA <= NOP_INSTR;
         ControlWord_MA <= '0;
         aluResult_MA   <= '0;
         op2_MA         <= '0;
         PC_MA          <= '0;
      end else begin
         instruction_MA <= instruction_EX;
         ControlWord_MA <= ControlWord;
         aluResult_MA   <= alu_result;
         op2_MA         <= op2;
         PC_MA          <= PC;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops plus branch, divide and reset sequences.
module tb_execute_stage;
   import tinyrisc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction_EX;
   logic [21:0] ControlWord;
   logic [31:0] BranchTarget, A, B, op2, PC;
   logic        stall, isBranchTaken;
   logic [31:0] branchPC, instruction_MA, aluResult_MA, op2_MA, PC_MA;
   logic [21:0] ControlWord_MA;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instruction_EX (instruction_EX),
      .ControlWord    (ControlWord),
      .BranchTarget   (BranchTarget),
      .A              (A),
      .B              (B),
      .op2            (op2),
      .PC             (PC),
      .stall          (stall),
      .isBranchTaken  (isBranchTaken),
      .branchPC       (branchPC),
      .instruction_MA (instruction_MA),
      .ControlWord_MA (ControlWord_MA),
      .aluResult_MA   (aluResult_MA),
      .op2_MA         (op2_MA),
      .PC_MA          (PC_MA)
   );

   typedef struct {
      string       name;
      logic [21:0] cw;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [21:0] cwb(input int i);
      return 22'(1) << i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [21:0] c, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] op2_i, input logic [31:0] pc_i, input logic [31:0] bt_i,
                        input logic [31:0] instr_i);
      ControlWord    = c;
      A              = a_i;
      B              = b_i;
      op2            = op2_i;
      PC             = pc_i;
      BranchTarget   = bt_i;
      instruction_EX = instr_i;
   endtask

   task automatic br_seq(input string name, input logic [31:0] ca, input logic [31:0] cb,
                         input logic [21:0] bcw, input logic [31:0] bt, input logic [31:0] ra,
                         input logic exp_taken, input logic [31:0] exp_pc);
      drive(cwb(CW_ISCMP), ca, cb, 0, 32'h500, 0, 32'h2000_0001);
      @(posedge clk); #1;
      drive(bcw, ra, 0, 0, 32'h504, bt, 32'h2000_0002);
      @(negedge clk);
      chk({name, "_taken"}, 32'(isBranchTaken), 32'(exp_taken));
      if (exp_taken) chk({name, "_pc"}, branchPC, exp_pc);
      @(posedge clk); #1;
   endtask

   task automatic run_div(input string name, input logic [21:0] c, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] exp_res, input int exp_stall);
      int n = 0;
      bit bub_ok = 1'b1;
      bit ended = 1'b0;
      drive(c, a_i, b_i, 0, 32'h3000, 0, 32'h3000_00AA);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall) begin
            ended = 1'b1;
            break;
         end
         n++;
         @(posedge clk); #1;
         if (instruction_MA !== NOP_INSTR || ControlWord_MA !== 22'd0 || aluResult_MA !== 32'd0)
            bub_ok = 1'b0;
      end
      chk({name, "_completes"}, 32'(ended), 32'd1);
      chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
      chk({name, "_bubbles"}, 32'(bub_ok), 32'd1);
      @(posedge clk); #1;
      chk({name, "_result"}, aluResult_MA, exp_res);
      chk({name, "_instr"}, instruction_MA, 32'h3000_00AA);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"add",  cwb(CW_ISADD),  32'd5,         32'd7,         32'h100, 32'd12};
      vecs[1]  = '{"sub",  cwb(CW_ISSUB),  32'd3,         32'd5,         32'h104, 32'hFFFF_FFFE};
      vecs[2]  = '{"mul",  cwb(CW_ISMUL),  32'd6,         32'd7,         32'h108, 32'd42};
      vecs[3]  = '{"mulw", cwb(CW_ISMUL),  32'hFFFF_FFFF, 32'd2,         32'h10C, 32'hFFFF_FFFE};
      vecs[4]  = '{"and",  cwb(CW_ISAND),  32'h0000_F0F0, 32'h0000_FF00, 32'h110, 32'h0000_F000};
      vecs[5]  = '{"or",   cwb(CW_ISOR),   32'h0000_F0F0, 32'h0000_FF00, 32'h114, 32'h0000_FFF0};
      vecs[6]  = '{"not",  cwb(CW_ISNOT),  32'd9,         32'h0000_00FF, 32'h118, 32'hFFFF_FF00};
      vecs[7]  = '{"mov",  cwb(CW_ISMOV),  32'd9,         32'h55,        32'h11C, 32'h55};
      vecs[8]  = '{"asr",  cwb(CW_ISASR),  32'h8000_0000, 32'd4,         32'h120, 32'hF800_0000};
      vecs[9]  = '{"lsr",  cwb(CW_ISLSR),  32'h8000_0000, 32'd4,         32'h124, 32'h0800_0000};
      vecs[10] = '{"lsl",  cwb(CW_ISLSL),  32'd1,         32'd33,        32'h128, 32'd2};
      vecs[11] = '{"call", cwb(CW_ISCALL), 32'd0,         32'd0,         32'h200, 32'h204};
      vecs[12] = '{"cmp",  cwb(CW_ISCMP),  32'd3,         32'd3,         32'h12C, 32'd0};
      vecs[13] = '{"ld",   cwb(CW_ISLD) | cwb(CW_ISWB), 32'h10, 32'd4,   32'h130, 32'h14};

      // reset: divide and unconditional branch requests must both be suppressed
      rst_n = 1'b0;
      drive(cwb(CW_ISUBRANCH) | cwb(CW_ISDIV), 32'd1, 32'd1, 0, 0, 32'h40, 32'h1111_1111);
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_taken", 32'(isBranchTaken), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr_ma", instruction_MA, NOP_INSTR);
      chk("rst_cw_ma", 32'(ControlWord_MA), 32'd0);
      chk("rst_alu_ma", aluResult_MA, 32'd0);
      chk("rst_op2_ma", op2_MA, 32'd0);
      chk("rst_pc_ma", PC_MA, 32'd0);
      drive(22'd0, 0, 0, 0, 0, 0, NOP_INSTR);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // flags reset to zero: beq straight after reset is not taken
      drive(cwb(CW_ISBEQ), 0, 0, 0, 32'h50, 32'h40, 32'h2000_0000);
      @(negedge clk);
      chk("beq_after_rst", 32'(isBranchTaken), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].cw, vecs[i].a, vecs[i].b, 32'hA000 + 32'(i), vecs[i].pc, 32'h0, 32'h1000_0000 + 32'(i));
         @(negedge clk);
         chk({vecs[i].name, "_stall"}, 32'(stall), 32'd0);
         @(posedge clk); #1;
         chk({vecs[i].name, "_res"}, aluResult_MA, vecs[i].res);
         chk({vecs[i].name, "_cw"}, 32'(ControlWord_MA), 32'(vecs[i].cw));
         chk({vecs[i].name, "_instr"}, instruction_MA, 32'h1000_0000 + 32'(i));
         chk({vecs[i].name, "_op2"}, op2_MA, 32'hA000 + 32'(i));
         chk({vecs[i].name, "_pc"}, PC_MA, vecs[i].pc);
      end

      br_seq("beq_eq",   32'd3, 32'd3, cwb(CW_ISBEQ), 32'h40, 0, 1'b1, 32'h40);
      br_seq("beq_ne",   32'd3, 32'd4, cwb(CW_ISBEQ), 32'h40, 0, 1'b0, 32'h40);
      br_seq("bgt_gt",   32'd5, 32'd3, cwb(CW_ISBGT), 32'h80, 0, 1'b1, 32'h80);
      br_seq("bgt_sign", 32'hFFFF_FFFF, 32'd1, cwb(CW_ISBGT), 32'h80, 0, 1'b0, 32'h80);
      br_seq("ret", 32'd0, 32'd1, cwb(CW_ISRET) | cwb(CW_ISUBRANCH), 32'h9999, 32'h1234, 1'b1, 32'h1234);

      // divides issued back to back
      run_div("div_100_7",  cwb(CW_ISDIV), 32'd100, 32'd7, 32'd14, 33);
      run_div("mod_m7_2",   cwb(CW_ISMOD), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_div("div_m7_2",   cwb(CW_ISDIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_div("div_7_m2",   cwb(CW_ISDIV), 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run_div("div_9_0",    cwb(CW_ISDIV), 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
      run_div("mod_9_0",    cwb(CW_ISMOD), 32'd9, 32'd0, 32'd9, 1);

      // reset lands on the tenth BUSY cycle of a divide
      drive(cwb(CW_ISDIV), 32'd100, 32'd7, 0, 32'h3000, 0, 32'h3000_00BB);
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_pre_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      drive(22'd0, 0, 0, 0, 0, 0, NOP_INSTR);
      #1;
      chk("midrst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("midrst_instr_ma", instruction_MA, NOP_INSTR);
      chk("midrst_alu_ma", aluResult_MA, 32'd0);
      chk("midrst_fsm", 32'(dut.u_div.state), 32'(DIV_IDLE));
      rst_n = 1'b1;
      run_div("post_rst_div", cwb(CW_ISDIV), 32'd9, 32'd0, 32'hFFFF_FFFF, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
